matrix_vector_prod_param: RTL
=============================

# matrix_vector_prod_param

Parametrised, sequential, fixed-point N×N matrix–vector multiplier. It supersedes the fixed 4×4 sequential product block in the accelerator datapath. Operands are captured through a valid/ready input handshake, computed with one multiply-accumulate per cycle, and presented through a valid/ready output handshake. It adds an optional transpose mode and per-element saturation flags.

## Interface
- `N`, 4: matrix dimension (N×N matrix, N-element vectors); N ≥ 2.
- `W`, 16: signed two's-complement element width.
- `FRAC`, 8: fractional bits (Q(W-FRAC).FRAC); 0 ≤ FRAC < W.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: operand set valid.
- `i_ready` out 1: block can accept an operand set.
- `i_transpose` in 1: 1 means compute Aᵀ·x; captured with the operands.
- `i_mat` in N*N*W: element (r,c) at bits [(r*N+c)*W +: W].
- `i_vec` in N*W: element c at [c*W +: W].
- `o_prod` out N*W: result element r at [r*W +: W].
- `o_sat` out N: bit r set means element r saturated.
- `o_valid` out 1: result valid.
- `o_ready` in 1: consumer accepts the result.

## Operation
- **States:** IDLE, COMPUTE, DONE.
- **IDLE:** `i_ready`=1. If `i_valid`, register `i_mat`, `i_vec` and `i_transpose`, clear row/col counters and the accumulator, then go to COMPUTE.
- **COMPUTE:** `i_ready`=0. Each cycle performs acc += a·x[c], where a = A[r][c] (normal) or A[c][r] (transpose).
  - Column counter c runs 0..N-1, then wraps to 0 and increments row r.
  - On the c=N-1 cycle, write row r's result into `o_prod`/`o_sat` and clear acc for the next row.
  - After r=N-1, c=N-1, go to DONE.
- **DONE:** `o_valid`=1; `o_prod` and `o_sat` are held stable. When `o_ready`=1, go to IDLE.
- `i_valid` is ignored outside IDLE. Captured operands are immune to input changes after capture.
- **Arithmetic:**
  - Product is 2W bits signed.
  - Accumulator ACC_W = 2W + clog2(N) bits signed; it never wraps.
  - Row result = acc >>> FRAC (arithmetic shift, truncation toward −∞).
  - Saturate to W bits: above 2^(W-1)-1 gives 0x7F..F, below −2^(W-1) gives 0x80..0. The matching `o_sat` bit is set when clamped, cleared otherwise.
- **Reset (`rst` low, at any time including mid-COMPUTE or DONE):** state=IDLE; `o_prod`=0, `o_sat`=0, `o_valid`=0, `i_ready`=0 while `rst` low. Counters, accumulator and operand registers are cleared. `i_ready`=1 immediately after `rst` rises.

## Timing
- Capture at the handshake edge E0. MACs occur on edges E1..E(N·N). `o_valid` rises after edge E(N·N), giving a latency of N·N cycles (16 for N=4).
- `o_valid` is 0 during IDLE and COMPUTE. `i_ready` is 0 during COMPUTE and DONE.
- Output handshake completes on the edge where `o_valid`&&`o_ready`. `i_ready`=1 in the following cycle.
- There is no back-to-back overlap: minimum interval between captures is N·N+2 cycles with `o_ready` held at 1.
- `o_prod` rows update during COMPUTE but are only meaningful while `o_valid`=1. Consumers must not sample otherwise.
- `i_ready`, `o_valid` are decoded from registered state (no combinational path from `i_valid`/`o_ready`).

## Test plan
All values use N=4, W=16, FRAC=8 (1.0 = 0x0100).
- **Identity:** A=I (diagonal 0x0100), x=[0x0100,0x0200,0x0300,0x0400], normal mode → `o_prod`=[0x0100,0x0200,0x0300,0x0400], `o_sat`=0. `o_valid` rises exactly 16 cycles after capture.
- **Transpose:** A row 0 all 0x0100, other rows 0, x all 0x0100. Normal → [0x0400,0,0,0]; transpose → [0x0100,0x0100,0x0100,0x0100].
- **Saturation / truncation:**
  - A all 0x7FFF, x all 0x7FFF → all 0x7FFF, `o_sat`=4'b1111.
  - A all 0x8000, x all 0x7FFF → all 0x8000, `o_sat`=4'b1111.
  - A[0][0]=0x0080, x[0]=0xFF01, rest 0 → `o_prod`[0]=0xFF80 (floor), `o_sat`=0.
- **Back-pressure:** hold `o_ready`=0 for 5 cycles in DONE while toggling `i_valid` with new operands. `o_prod` is unchanged, `i_ready`=0, and the second set is captured only after the handshake.
- **Reset mid-compute:** drop `rst` at the 7th COMPUTE cycle → `o_valid`=0, `o_prod`=0, `o_sat`=0 asynchronously. After release, `i_ready`=1 and a subsequent identity test passes with 16-cycle latency.
- **Randomised:** 200 random operand sets, random `i_transpose` and random `o_ready` stalls, checked against a bit-exact reference model (ACC_W accumulator, floor shift, saturation).

Source files
------------

// File: rtl/matrix_vector_prod_param_if.sv
// Operand/result handshake bundle for matrix_vector_prod_param.
// Slave side is the multiplier; master side is the producer/consumer.
interface matrix_vector_prod_param_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
);
  logic             i_valid;
  logic             i_ready;
  logic             i_transpose;
  logic [N*N*W-1:0] i_mat;
  logic [N*W-1:0]   i_vec;
  logic [N*W-1:0]   o_prod;
  logic [N-1:0]     o_sat;
  logic             o_valid;
  logic             o_ready;

  modport slave (
    input  i_valid, i_transpose, i_mat, i_vec, o_ready,
    output i_ready, o_prod, o_sat, o_valid
  );

  modport master (
    output i_valid, i_transpose, i_mat, i_vec, o_ready,
    input  i_ready, o_prod, o_sat, o_valid
  );
endinterface

// File: rtl/matrix_vector_prod_param.sv
// Sequential fixed-point NxN matrix-vector multiplier, one MAC per cycle,
// with optional transpose and per-element saturation flags.
module matrix_vector_prod_param #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 8
) (
  input logic                      clk,
  input logic                      rst,
  matrix_vector_prod_param_if.slave bus
);

  localparam int unsigned CntW = $clog2(N);
  localparam int unsigned AccW = 2 * W + $clog2(N);

  localparam logic signed [AccW-1:0] SatMax = {{(AccW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(AccW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e                 state_q;
  logic [N*N*W-1:0]       mat_q;
  logic [N*W-1:0]         vec_q;
  logic                   transpose_q;
  logic [CntW-1:0]        row_q;
  logic [CntW-1:0]        col_q;
  logic signed [AccW-1:0] acc_q;
  logic [N*W-1:0]         prod_q;
  logic [N-1:0]           sat_q;

  int unsigned            elem_idx;
  logic signed [W-1:0]    a_el;
  logic signed [W-1:0]    x_el;
  logic signed [2*W-1:0]  mult;
  logic signed [AccW-1:0] acc_sum;
  logic signed [AccW-1:0] shifted;
  logic [W-1:0]           row_res;
  logic                   row_sat;

  always_comb begin
    elem_idx = '0;
    if (transpose_q) begin
      elem_idx = int'(col_q) * N + int'(row_q);
    end else begin
      elem_idx = int'(row_q) * N + int'(col_q);
    end
    a_el    = mat_q[elem_idx*W +: W];
    x_el    = vec_q[int'(col_q)*W +: W];
    mult    = (2 * W)'(a_el) * (2 * W)'(x_el);
    acc_sum = acc_q + AccW'(mult);
    // Arithmetic shift floors toward -inf, matching Q-format truncation.
    shifted = acc_sum >>> FRAC;
    row_sat = 1'b0;
    row_res = W'(shifted);
    if (shifted > SatMax) begin
      row_sat = 1'b1;
      row_res = {1'b0, {(W - 1){1'b1}}};
    end else if (shifted < SatMin) begin
      row_sat = 1'b1;
      row_res = {1'b1, {(W - 1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mat_q       <= '0;
      vec_q       <= '0;
      transpose_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      sat_q       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.i_valid) begin
            mat_q       <= bus.i_mat;
            vec_q       <= bus.i_vec;
            transpose_q <= bus.i_transpose;
            row_q       <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            state_q     <= StCompute;
          end
        end
        StCompute: begin
          if (col_q == CntW'(N - 1)) begin
            prod_q[int'(row_q)*W +: W] <= row_res;
            sat_q[row_q]               <= row_sat;
            acc_q                      <= '0;
            col_q                      <= '0;
            if (row_q == CntW'(N - 1)) begin
              row_q   <= '0;
              state_q <= StDone;
            end else begin
              row_q <= row_q + CntW'(1);
            end
          end else begin
            acc_q <= acc_sum;
            col_q <= col_q + CntW'(1);
          end
        end
        StDone: begin
          if (bus.o_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset gates i_ready so nothing is offered while the block is held in reset.
  assign bus.i_ready = rst && (state_q == StIdle);
  assign bus.o_valid = (state_q == StDone);
  assign bus.o_prod  = prod_q;
  assign bus.o_sat   = sat_q;

endmodule
